// File: rtl/dmem_mmio.sv
// Memory-stage data port: word RAM with combinational reads, plus a
// memory-mapped UART transmitter (TX FIFO feeding an 8N1 serializer).
module dmem_mmio #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned CLK_DIV     = 16,
  parameter logic [31:0] UART_BASE   = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        uart_tx,
  output logic        tx_busy
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned DW = $clog2(CLK_DIV);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_e;

  logic [31:0]   mem [DEPTH_WORDS];
  logic [7:0]    fifo_q [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q;
  logic          ovf_q;
  tx_state_e     state_q;
  logic [7:0]    shift_q;
  logic [DW-1:0] cnt_q;
  logic [2:0]    idx_q;
  logic          tx_q;

  logic ram_sel_c, tx_sel_c, stat_sel_c;
  logic empty_c, full_c, bit_end_c;
  logic push_c, pop_c;
  logic unused_c;

  // Word-granular decode; byte offset bits are don't-care.
  assign ram_sel_c  = (addr[31:2] < 30'(DEPTH_WORDS));
  assign tx_sel_c   = (addr[31:2] == UART_BASE[31:2]);
  assign stat_sel_c = (addr[31:2] == (UART_BASE[31:2] + 30'd1));
  assign unused_c   = ^{addr[1:0], writedata[31:8]};

  assign empty_c   = (count_q == '0);
  assign full_c    = (count_q == CW'(FIFO_DEPTH));
  assign bit_end_c = (cnt_q == DW'(CLK_DIV - 1));

  // Full is judged on the pre-pop count, so a push into a full FIFO always drops.
  assign push_c = memwrite && tx_sel_c && !full_c;
  assign pop_c  = !empty_c && ((state_q == S_IDLE) || ((state_q == S_STOP) && bit_end_c));

  assign tx_busy = (state_q != S_IDLE);
  assign uart_tx = tx_q;

  always_comb begin
    readdata = '0;
    if (ram_sel_c) begin
      readdata = mem[addr[AW+1:2]];
    end else if (stat_sel_c) begin
      readdata = {28'b0, ovf_q, tx_busy, full_c, empty_c};
    end
  end

  // Storage arrays carry no reset.
  always_ff @(posedge clk) begin
    if (memwrite && ram_sel_c) begin
      mem[addr[AW+1:2]] <= writedata;
    end
    if (reset && push_c) begin
      fifo_q[wr_ptr_q] <= writedata[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      state_q  <= S_IDLE;
      shift_q  <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      tx_q     <= 1'b1;
    end else begin
      if (push_c) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (push_c && !pop_c) begin
        count_q <= count_q + CW'(1);
      end else if (!push_c && pop_c) begin
        count_q <= count_q - CW'(1);
      end

      if (memwrite && tx_sel_c && full_c) begin
        ovf_q <= 1'b1;
      end else if (memwrite && stat_sel_c) begin
        ovf_q <= 1'b0;
      end

      unique case (state_q)
        S_IDLE: begin
          tx_q  <= 1'b1;
          cnt_q <= '0;
          if (!empty_c) begin
            shift_q <= fifo_q[rd_ptr_q];
            tx_q    <= 1'b0;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (bit_end_c) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            tx_q    <= shift_q[0];
            state_q <= S_DATA;
          end else begin
            cnt_q <= cnt_q + DW'(1);
          end
        end
        S_DATA: begin
          if (bit_end_c) begin
            cnt_q <= '0;
            if (idx_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= S_STOP;
            end else begin
              idx_q   <= idx_q + 3'd1;
              shift_q <= shift_q >> 1;
              tx_q    <= shift_q[1];
            end
          end else begin
            cnt_q <= cnt_q + DW'(1);
          end
        end
        S_STOP: begin
          if (bit_end_c) begin
            cnt_q <= '0;
            if (!empty_c) begin
              shift_q <= fifo_q[rd_ptr_q];
              tx_q    <= 1'b0;
              state_q <= S_START;
            end else begin
              state_q <= S_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + DW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_mmio.sv
// Bench for dmem_mmio: directed and random RAM/UART traffic checked against
// an array/queue reference model and a line-level 8N1 frame decoder.
module tb_dmem_mmio;

  localparam int unsigned CDIV = 4;
  localparam logic [31:0] TXD = 32'h0000_1000;
  localparam logic [31:0] STS = 32'h0000_1004;

  logic        clk;
  logic        reset;
  logic        memwrite;
  logic [31:0] addr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        uart_tx;
  logic        tx_busy;

  int errors = 0;
  int checks = 0;
  int mon_err = 0;

  logic [31:0] ram_m [64];
  bit          ram_v [64];
  logic [7:0]  exp_q [$];
  logic [7:0]  rx_q  [$];

  dmem_mmio #(
    .DEPTH_WORDS(64),
    .FIFO_DEPTH (8),
    .CLK_DIV    (CDIV),
    .UART_BASE  (32'h0000_1000)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .memwrite (memwrite),
    .addr     (addr),
    .writedata(writedata),
    .readdata (readdata),
    .uart_tx  (uart_tx),
    .tx_busy  (tx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // Line decoder: samples mid-bit; frames interrupted by a return to idle are discarded.
  initial begin : mon
    logic [7:0] b;
    logic       ok;
    logic       stopb;
    forever begin
      @(negedge clk);
      if (uart_tx === 1'b0) begin
        ok = 1'b1;
        b  = '0;
        repeat (2) @(negedge clk);
        if (uart_tx !== 1'b0 || tx_busy !== 1'b1) ok = 1'b0;
        for (int k = 0; k < 8; k++) begin
          repeat (CDIV) @(negedge clk);
          if (tx_busy !== 1'b1) ok = 1'b0;
          b[k] = uart_tx;
        end
        repeat (CDIV) @(negedge clk);
        if (tx_busy !== 1'b1) ok = 1'b0;
        stopb = uart_tx;
        if (ok) begin
          rx_q.push_back(b);
          if (stopb !== 1'b1) mon_err++;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Caller is in the low clock phase; the write happens on the next rising edge.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    memwrite  = 1'b1;
    addr      = a;
    writedata = d;
    @(negedge clk);
    memwrite  = 1'b0;
  endtask

  task automatic rdchk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    @(negedge clk);
    addr = a;
    #1;
    chk(tag, readdata, exp);
  endtask

  task automatic ram_wr(input int idx, input logic [31:0] d);
    wr(32'(idx * 4), d);
    ram_m[idx] = d;
    ram_v[idx] = 1'b1;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    repeat (2) @(negedge clk);
    while (tx_busy === 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 32'(tx_busy), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  initial begin : main
    logic [9:0]  fr;
    logic [7:0]  by;
    logic [31:0] d;
    int idx, cnt, guard, n, n0;

    reset = 1'b0; memwrite = 1'b0; addr = '0; writedata = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    addr  = STS;
    #1;
    chk("rst_status", readdata, 32'h1);
    chk("rst_tx", 32'(uart_tx), 32'd1);
    chk("rst_busy", 32'(tx_busy), 32'd0);

    // RAM basics, byte-offset don't-care, unmapped space and aliasing boundaries
    ram_wr(4, 32'hDEAD_BEEF);
    rdchk("ram_0x10", 32'h10, 32'hDEAD_BEEF);
    rdchk("ram_0x13", 32'h13, 32'hDEAD_BEEF);
    rdchk("unmapped_rd", 32'h2000, 32'h0);
    rdchk("txdata_rd", TXD, 32'h0);
    ram_wr(63, 32'h1234_5678);
    ram_wr(0, 32'hCAFE_F00D);
    wr(32'h100, 32'hBAD0_BAD0);
    wr(32'h2000, 32'hFFFF_FFFF);
    rdchk("ram_end_plus1", 32'h100, 32'h0);
    rdchk("ram_word0", 32'h0, 32'hCAFE_F00D);
    rdchk("ram_last", 32'hFC, 32'h1234_5678);
    rdchk("ram_0x10_kept", 32'h10, 32'hDEAD_BEEF);
    rdchk("status_after_unmapped", STS, 32'h1);

    // Random RAM traffic against the array model
    for (int i = 0; i < 24; i++) begin
      idx = int'($urandom_range(0, 63));
      d   = $urandom;
      @(negedge clk);
      ram_wr(idx, d);
      rdchk("ram_rand_wb", 32'(idx * 4 + int'($urandom_range(0, 3))), ram_m[idx]);
      idx = int'($urandom_range(0, 63));
      if (ram_v[idx]) rdchk("ram_rand_rd", 32'(idx * 4 + int'($urandom_range(0, 3))), ram_m[idx]);
    end

    // Single frame 0xA5, cycle-exact line shape
    @(negedge clk);
    wr(TXD, 32'h0000_00A5);
    exp_q.push_back(8'hA5);
    chk("a5_pre_tx", 32'(uart_tx), 32'd1);
    chk("a5_pre_busy", 32'(tx_busy), 32'd0);
    fr = {1'b1, 8'hA5, 1'b0};
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      chk($sformatf("a5_line_c%0d", c), 32'(uart_tx), 32'(fr[c / CDIV]));
      chk($sformatf("a5_busy_c%0d", c), 32'(tx_busy), 32'd1);
    end
    @(negedge clk);
    chk("a5_end_busy", 32'(tx_busy), 32'd0);
    chk("a5_end_tx", 32'(uart_tx), 32'd1);

    // Back-to-back frames
    @(negedge clk);
    wr(TXD, 32'h55);
    wr(TXD, 32'h0F);
    exp_q.push_back(8'h55);
    exp_q.push_back(8'h0F);
    addr = STS;
    #1;
    chk("b2b_status_queued", readdata, 32'h4);
    cnt = 0;
    guard = 0;
    while (tx_busy === 1'b1 && guard < 300) begin
      cnt++;
      if (cnt == 50) chk("b2b_status_popped", readdata, 32'h5);
      @(negedge clk);
      guard++;
    end
    chk("b2b_busy_cycles", 32'(cnt), 32'd80);
    repeat (3) @(negedge clk);

    // Overflow: 10 consecutive pushes, the tenth is dropped
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      by = 8'($urandom);
      wr(TXD, {24'h0, by});
      if (i < 9) exp_q.push_back(by);
    end
    addr = STS;
    #1;
    chk("ovf_status", readdata, 32'hE);
    wr(STS, $urandom);
    addr = STS;
    #1;
    chk("ovf_cleared", readdata, 32'h6);
    wait_idle(9 * 40 + 40);
    rdchk("ovf_drained_status", STS, 32'h1);

    // Random bursts that cannot overflow
    for (int bi = 0; bi < 3; bi++) begin
      n = int'($urandom_range(1, 8));
      @(negedge clk);
      for (int i = 0; i < n; i++) begin
        by = 8'($urandom);
        wr(TXD, {24'h0, by});
        exp_q.push_back(by);
      end
      addr = STS;
      #1;
      chk("burst_no_ovf", 32'(readdata[3]), 32'd0);
      wait_idle(n * 40 + 60);
    end

    chk("frame_count", 32'(rx_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      chk($sformatf("frame_byte%0d", i), 32'(rx_q[i]), 32'(exp_q[i]));
    end
    chk("stop_bits", 32'(mon_err), 32'd0);

    // Reset in the middle of a data phase with three bytes queued
    @(negedge clk);
    ram_wr(8, 32'h600D_F00D);
    for (int i = 0; i < 4; i++) wr(TXD, $urandom);
    repeat (20) @(negedge clk);
    n0 = rx_q.size();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("midrst_tx", 32'(uart_tx), 32'd1);
    chk("midrst_busy", 32'(tx_busy), 32'd0);
    addr = STS;
    #1;
    chk("midrst_status", readdata, 32'h1);
    repeat (200) @(negedge clk);
    chk("midrst_no_frames", 32'(rx_q.size()), 32'(n0));
    chk("midrst_idle", 32'(tx_busy), 32'd0);
    rdchk("midrst_ram_kept", 32'h20, 32'h600D_F00D);
    rdchk("midrst_ram_kept2", 32'h11, ram_m[4]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_mmio.md
Name: dmem_mmio

Overview:
Data-memory subsystem on the core's memory-stage port. It consumes memwrite/address/write-data and returns read data in the same cycle. It contains a word-addressed data RAM and a memory-mapped UART transmitter (TX FIFO, 8N1 serializer), giving the core a byte output channel for test programs.

Parameters:
DEPTH_WORDS, 64, number of 32-bit RAM words; RAM occupies 0x0000_0000 .. DEPTH_WORDS*4-1
FIFO_DEPTH, 8, TX FIFO entries (power of two, >=2)
CLK_DIV, 16, clock cycles per UART bit (>=2)
UART_BASE, 32'h0000_1000, base address of UART registers

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-low reset (0 = reset, sampled on rising clk)
memwrite  input  1  store enable for current address
addr  input  32  byte address (aluresult of memory stage)
writedata  input  32  store data
readdata  output  32  load data, combinational from addr
uart_tx  output  1  serial line, idle high, registered
tx_busy  output  1  high while a frame is being shifted out

Behaviour:
- Address decode (addr[1:0] ignored everywhere):
  - RAM: addr < DEPTH_WORDS*4.
  - TXDATA: UART_BASE+0.
  - STATUS: UART_BASE+4.
  - Anything else: unmapped.
- Reads are combinational, same cycle:
  - RAM returns word addr[log2(DEPTH_WORDS)+1:2].
  - TXDATA reads 0.
  - STATUS reads {28'b0, overflow, busy, full, empty}.
  - Unmapped reads 0.
- RAM write occurs on the rising edge when memwrite=1. Write-then-read of the same word returns new data from the next cycle on. RAM contents are not reset.
- TXDATA write (memwrite=1): writedata[7:0] is pushed if FIFO is not full. If full, the byte is dropped and overflow is set (sticky). Full is evaluated before any same-cycle pop, so a push when full is always dropped.
- STATUS write: clears overflow; data is ignored.
- Unmapped writes are ignored with no side effects.
- FIFO:
  - Circular buffer with wrapping read/write pointers and a count of 0..FIFO_DEPTH.
  - empty = (count==0); full = (count==FIFO_DEPTH).
  - Simultaneous push and pop on a non-full FIFO leaves count unchanged.
- TX FSM states: IDLE, START, DATA, STOP. A bit counter counts 0..CLK_DIV-1; a bit index counts 0..7.
  - IDLE: uart_tx=1. If FIFO non-empty: pop into shift register, uart_tx<=0, go to START.
  - START: hold for CLK_DIV cycles, then go to DATA and drive shift[0].
  - DATA: shift LSB first, each bit held CLK_DIV cycles. After bit 7, uart_tx<=1 and go to STOP.
  - STOP: hold 1 for CLK_DIV cycles. At its end, if FIFO non-empty, pop and go directly to START (back-to-back, no idle gap). Otherwise go to IDLE.
- Timing:
  - Push at edge N gives uart_tx falling after edge N+1 when the FSM was IDLE.
  - A frame is exactly 10*CLK_DIV cycles.
- tx_busy = (state != IDLE).
- Reset (reset=0 at a rising edge, including mid-frame):
  - state=IDLE, uart_tx=1, tx_busy=0.
  - FIFO emptied (pointers=0, count=0), overflow=0, counters=0.
  - A partially sent frame is abandoned; the line returns high immediately after the reset edge.
  - RAM is unchanged.
  - readdata for STATUS after reset = 32'h1.

Test Plan:
- Reset, then read STATUS -> readdata=32'h0000_0001, uart_tx=1, tx_busy=0.
- Write 32'hDEADBEEF to 0x0000_0010, then read 0x10 and 0x13 -> both return 32'hDEADBEEF. Read 0x2000 -> 0. A write to 0x2000 must not alter any RAM word or the FIFO.
- CLK_DIV=4: write 32'h000000A5 to TXDATA -> uart_tx low one cycle after the write edge for 4 cycles. Then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high 4 cycles. tx_busy high for exactly 40 cycles.
- CLK_DIV=4: write 0x55 then 0x0F on consecutive cycles -> two frames with no idle gap (80 cycles busy). STATUS empty=1 once the second byte is popped.
- FIFO_DEPTH=8: write 10 bytes in consecutive cycles while the first frame runs:
  - 1 byte is popped into the shifter.
  - 8 bytes are queued (full=1).
  - 1 byte is dropped, so overflow=1.
  - A later STATUS write clears overflow. Exactly 9 frames appear on the line.
- Assert reset=0 mid-DATA of a frame with 3 bytes queued -> next cycle uart_tx=1, tx_busy=0, STATUS=32'h1. No further frames. A RAM word written before reset reads back unchanged.
